sll_iter: RTL and testbench



---
 rtl/sll_iter_pkg.sv | 13 +
 rtl/sll_iter_sll1.sv | 11 +
 rtl/sll_iter.sv | 110 +++++++++++
 tb/tb_sll_iter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sll_iter_pkg.sv
// Shared constants and FSM encoding for the iterative left shifter.
package sll_iter_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sll_iter_sll1.sv
// Combinational single-position logical left shift.
module sll1
  import sll_iter_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = in << 1;

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: one bit position per clock, done pulse on completion.
module sll_iter
  import sll_iter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     sreg_q, sreg_d, sreg_sh;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 capture;

  // Only the low shift-amount bits matter; the rest of in2 is intentionally dropped.
  logic unused_in2;
  assign unused_in2 = ^in2[WIDTH-1:SHAMT_W];

  assign capture = start && !flush;

  sll1 u_sll1 (
    .in  (sreg_q),
    .out (sreg_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = (in2[SHAMT_W-1:0] != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          sreg_d = in1;
          cnt_d  = in2[SHAMT_W-1:0];
        end
      end
      SHIFT: begin
        if (!flush) begin
          sreg_d = sreg_sh;
          cnt_d  = cnt_q - SHAMT_W'(1);
        end
      end
      default: ;
    endcase
    if (state_d == DONE && state_q != DONE) begin
      out_d = sreg_d;
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_sll_iter.sv
// Directed self-checking bench for sll_iter.
module tb_sll_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int tests;
  int fails;

  sll_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .flush (flush),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Capture on the next edge, then expect done exactly n edges later.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] exp);
    in1   = a;
    in2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    in1   = 32'h5A5A_A5A5;
    in2   = 32'h0000_001F;
    for (int k = 0; k < n; k++) begin
      chk({tag, " busy-mid"}, 32'(busy), 32'd1);
      chk({tag, " done-early"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy-done"}, 32'(busy), 32'd1);
    chk({tag, " out"}, out, exp);
    tick();
    chk({tag, " done-after"}, 32'(done), 32'd0);
    chk({tag, " busy-after"}, 32'(busy), 32'd0);
    chk({tag, " out-hold"}, out, exp);
  endtask

  initial begin
    int ndone;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    in1   = '0;
    in2   = '0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst out", out, 32'd0);
    rst_n = 1'b1;
    #1;

    run_op("basic", 32'h0000_0001, 32'd4, 4, 32'h0000_0010);
    run_op("zero", 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF);
    run_op("upper", 32'h8000_0001, 32'hFFFF_FFE1, 1, 32'h0000_0002);
    run_op("max", 32'hFFFF_FFFF, 32'd31, 31, 32'h8000_0000);

    // Start while busy must be ignored.
    in1 = 32'h3; in2 = 32'd8; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        in1 = 32'h1; in2 = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
      if (c == 9) chk("busy-start out", out, 32'h0000_0300);
      tick();
    end
    chk("busy-start ndone", 32'(ndone), 32'd1);
    chk("busy-start idle", 32'(busy), 32'd0);

    // Flush mid-SHIFT: no done, out untouched.
    in1 = 32'h0000_00FF; in2 = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush out", out, 32'h0000_0300);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("flush no-done", 32'(ndone), 32'd0);

    // Flush and start together in IDLE: nothing captured.
    in1 = 32'h1; in2 = 32'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush-start busy", 32'(busy), 32'd0);
    chk("flush-start done", 32'(done), 32'd0);
    tick();
    chk("flush-start out", out, 32'h0000_0300);

    // Async reset mid-SHIFT.
    in1 = 32'h0000_0007; in2 = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out", out, 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    run_op("post-rst", 32'h0000_0003, 32'd2, 2, 32'h0000_000C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
